// File: rtl/cpu_down_timer.sv
// Loadable down-counter/timer with one-shot and periodic (auto-reload) modes.
// Emits a registered one-cycle tc_pulse on expiry and holds done after a one-shot expires.
module cpu_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    output logic [W-1:0] count,
    output logic         running,
    output logic         tc_pulse,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Priority: load > stop > start > counting. stop and start only act in
    // the states where they mean something, so stop outside RUN lets start through.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start && state_q != RUN) begin
            if (state_q == DONE) count_d = reload_q;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                if (periodic) count_d = reload_q;
                else          state_d = DONE;
            end
        end
    end

    assign count    = count_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign tc_pulse = tc_q;

endmodule

// File: tb/tb_cpu_down_timer.sv
// Scoreboarded bench for cpu_down_timer: the driver pushes the model's expected
// outputs per edge, a monitor pops and compares them after every rising edge.
module tb_cpu_down_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load, start, stop, periodic;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         running, tc_pulse, done;

    cpu_down_timer #(.W(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .periodic(periodic),
        .count(count), .running(running), .tc_pulse(tc_pulse), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit run;
        bit dn;
        bit tc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 = idle, 1 = counting, 2 = expired.
    int m_mode, m_cnt, m_rel;

    function automatic exp_t model_edge(bit ld, int lv, bit st, bit sp, bit per);
        exp_t e;
        bit   tc = 0;
        if (ld) begin
            m_cnt = lv; m_rel = lv; m_mode = 0;
        end else if (sp && m_mode == 1) begin
            m_mode = 0;
        end else if (st && m_mode != 1) begin
            if (m_mode == 2) m_cnt = m_rel;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
                tc = 1;
                if (per) m_cnt = m_rel;
                else     m_mode = 2;
            end
        end
        e.cnt = m_cnt; e.run = (m_mode == 1); e.dn = (m_mode == 2); e.tc = tc;
        return e;
    endfunction

    task automatic cyc(input bit ld, input int lv, input bit st, input bit sp, input bit per);
        @(negedge clk);
        load = ld; load_value = lv[W-1:0]; start = st; stop = sp; periodic = per;
        q.push_back(model_edge(ld, lv, st, sp, per));
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit per);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, per);
    endtask

    task automatic check_reset_now(input string tag);
        n_checks++;
        if (count !== 0 || running !== 0 || done !== 0 || tc_pulse !== 0) begin
            n_fail++;
            $display("FAIL %s: got count=%0d running=%0b done=%0b tc=%0b, want all 0",
                     tag, count, running, done, tc_pulse);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        load = 0; start = 0; stop = 0; periodic = 0; load_value = '0;
        #1 check_reset_now(tag);
        #1 reset = 1'b0;
        m_mode = 0; m_cnt = 0; m_rel = 0;
        q.push_back(model_edge(0, 0, 0, 0, 0));
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (count !== e.cnt[W-1:0] || running !== e.run || done !== e.dn || tc_pulse !== e.tc) begin
                n_fail++;
                $display("FAIL edge_check @%0t: got count=%0d run=%0b done=%0b tc=%0b, want count=%0d run=%0b done=%0b tc=%0b",
                         $time, count, running, done, tc_pulse, e.cnt, e.run, e.dn, e.tc);
            end
        end
    end

    initial begin
        int lat;
        bool_loop: begin end
        reset = 1'b1;
        load = 0; start = 0; stop = 0; periodic = 0; load_value = '0;
        m_mode = 0; m_cnt = 0; m_rel = 0;
        #1 check_reset_now("reset_initial");
        #12 reset = 1'b0;

        // 1: reset mid-operation, then one-shot from 5
        cyc(1, 7, 0, 0, 1); cyc(0, 0, 1, 0, 1); idle(3, 1);
        do_reset("reset_mid_run");
        cyc(1, 5, 0, 0, 0); cyc(0, 0, 1, 0, 0); idle(9, 0);

        // 2: periodic reload 3
        cyc(1, 3, 0, 0, 1); cyc(0, 0, 1, 0, 1); idle(12, 1);

        // 3: stop/resume
        cyc(1, 10, 0, 0, 0); cyc(0, 0, 1, 0, 0); idle(4, 0);
        cyc(0, 0, 0, 1, 0); idle(5, 0); cyc(0, 0, 1, 0, 0); idle(10, 0);

        // 4: load+start together; stop on terminal edge
        cyc(1, 4, 1, 0, 0); idle(2, 0);
        cyc(1, 2, 0, 0, 0); cyc(0, 0, 1, 0, 0); idle(2, 0);
        cyc(0, 0, 0, 1, 0); idle(3, 0);

        // 5: restart after one-shot expiry
        cyc(1, 3, 0, 0, 0); cyc(0, 0, 1, 0, 0); idle(6, 0);
        cyc(0, 0, 1, 0, 0); idle(6, 0);

        // 6: reload 0 periodic, then start with count 0 one-shot
        cyc(1, 0, 0, 0, 1); cyc(0, 0, 1, 0, 1); idle(5, 1);
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0); idle(3, 0);

        // 6b: load 255 one-shot: tc exactly 256 edges after the start edge
        cyc(1, 255, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            cyc(0, 0, 0, 0, 0);
            #1;
            if (tc_pulse === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat != 256) begin
            n_fail++;
            $display("FAIL latency_255: got %0d edges, want 256", lat);
        end
        idle(3, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, sp, per;
            int lv;
            ld  = ($urandom_range(0, 29) == 0);
            st  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 19) == 0);
            per = ($urandom_range(0, 3) != 0);
            lv  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            if (i % 997 == 500) do_reset("reset_random");
            else cyc(ld, lv, st, sp, per);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_down_timer.md
Name: cpu_down_timer

Overview:
- Loadable down-counter and timer. It is the count-down counterpart to the team's mod-N up-counter.
- Supports one-shot and periodic (auto-reload) modes, with a terminal-count pulse and a done flag.
- Used by the CPU for delay loops, watchdog-style timeouts and periodic tick generation.
- Sits on the control path and is driven by the control unit's load/start/stop strobes.

Parameters:
W, 8, width of counter, reload register and load_value.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  synchronous strobe: copy load_value into count and reload register
load_value  input  W  value captured on load
start  input  1  synchronous strobe: begin or resume counting
stop  input  1  synchronous strobe: pause counting, hold count
periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled every cycle
count  output  W  current counter value (registered)
running  output  1  high while state == RUN
tc_pulse  output  1  one-cycle pulse when the counter expires (registered)
done  output  1  high while state == DONE (one-shot expired)

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, count=0, reload=0, running=0, tc_pulse=0, done=0.
- Priority per edge: reset > load > stop > start > normal counting.
- tc_pulse defaults to 0 every edge unless set by the terminal-count rule below.

Load (any state):
- count<=load_value, reload<=load_value, state<=IDLE, tc_pulse<=0.
- Any concurrent stop/start is ignored.

Stop:
- In RUN: state<=IDLE, count held, no tc_pulse, even if count==0 that cycle.
- In IDLE or DONE: no effect.

Start:
- In IDLE: state<=RUN, count unchanged; the first decrement happens on the next edge.
- In DONE: count<=reload, state<=RUN (restart).
- In RUN: ignored.

RUN, count != 0:
- count<=count-1.

RUN, count == 0 (terminal):
- tc_pulse<=1.
- If periodic=1: count<=reload and stay in RUN.
- If periodic=0: state<=DONE and count stays 0.

Derived timing and corner cases:
- One-shot latency: start sampled at edge E0 with count=N. Decrements occur at E1..EN. tc_pulse and done rise at EN+1. Total = N+1 edges after the start edge.
- Periodic: tc_pulse every reload+1 cycles.
- reload=0 in periodic mode: tc_pulse high every cycle while running.
- start in IDLE with count==0: RUN for one cycle, then terminal at the next edge.
- No wrap-around below 0: count never decrements past 0.
- Reset mid-RUN: outputs go to reset values immediately, with no clock edge required.
- running and done are decoded from registered state. They are never both high.

Test Plan:
1. reset pulse mid-operation -> count=0, running=0, done=0, tc_pulse=0 immediately. load_value=5, load, then start with periodic=0 -> count 5,4,3,2,1,0 on successive edges. tc_pulse=1 for exactly one cycle 6 edges after the start edge. done=1, count stays 0.
2. load 3, periodic=1, start; run 12 cycles -> tc_pulse on every 4th edge. count sequence 3,2,1,0,3,2,1,0,... and running stays 1.
3. load 10, start, stop after 4 decrements (count=6), idle 5 cycles, start -> count holds 6 while idle, then resumes 5,4,...; tc_pulse after 7 further edges.
4. Simultaneous events: load+start same edge -> state IDLE with count=load_value. stop asserted on the terminal-count edge -> no tc_pulse, state IDLE, count=0.
5. One-shot expires with done=1, then start -> count reloads to reload value, done drops, running=1, and a second tc_pulse follows after reload+1 edges.
6. reload=0, periodic=1, start -> tc_pulse high every cycle. With W=8, load 255 one-shot -> 256 edges to tc_pulse and no underflow to 255.
